fetch_unit: RTL



---
 rtl/lc3b_types.sv | 21 ++
 rtl/fetch_unit_queue.sv | 64 ++++++
 rtl/fetch_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b datapath types.
//   lc3b_word        - 16-bit machine word / byte address.
//   lc3b_fetch_entry - fetched instruction paired with its incremented PC.
//   PC_RESET         - fetch PC after reset.
//   pc_inc()         - PC + 2, 16-bit modulo (FFFE wraps to 0000).
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef struct packed {
        lc3b_word word;
        lc3b_word pc;
    } lc3b_fetch_entry;

    localparam lc3b_word PC_RESET = 16'h0000;

    function automatic lc3b_word pc_inc(input lc3b_word pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// fetch_queue: 2-entry synchronous FIFO of fetched instructions.
//   push/push_entry - write an entry (ignored if it would overflow)
//   pop             - drop the head entry (ignored when empty)
//   flush           - empty the queue at the next edge; overrides push/pop
//   count           - number of valid entries (0..2)
//   head            - oldest entry, straight from a register
// Entry 0 is always the head; a pop shifts entry 1 down so the head output
// never goes through a read-pointer mux.
module fetch_queue
    import lc3b_types::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  lc3b_fetch_entry push_entry,
    input  logic            pop,
    input  logic            flush,
    output logic [1:0]      count,
    output lc3b_fetch_entry head
);

    lc3b_fetch_entry entry_q [2];
    lc3b_fetch_entry entry_d [2];
    logic [1:0]      count_q;
    logic [1:0]      count_d;
    logic            pop_ok;
    logic            push_ok;
    logic [1:0]      kept;

    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        pop_ok  = pop && (count_q != 2'd0);
        // Entries surviving this cycle's pop; also the slot a push lands in.
        kept    = count_q - {1'b0, pop_ok};
        push_ok = push && (kept < 2'd2);
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (pop_ok) begin
                entry_d[0] = entry_q[1];
            end
            if (push_ok) begin
                entry_d[kept[0]] = push_entry;
            end
            count_d = kept + {1'b0, push_ok};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= 2'd0;
            entry_q[0] <= '0;
            entry_q[1] <= '0;
        end else begin
            count_q <= count_d;
            entry_q <= entry_d;
        end
    end

    assign count = count_q;
    assign head  = entry_q[0];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: LC-3b instruction fetch stage feeding the IR.
//   clk, rst_n                - clock, asynchronous active-low reset
//   mem_address/mem_read      - outstanding instruction fetch (held until mem_resp)
//   mem_rdata/mem_resp        - returned word, one-cycle completion pulse
//   redirect/redirect_pc      - flush and restart fetch at redirect_pc (bit 0 forced 0)
//   ir_ready                  - IR can accept this cycle
//   ir_valid/ir_word/ir_pc    - registered queue head; ir_pc is the head address + 2
//   ir_load                   - ir_valid & ir_ready & ~redirect
module fetch_unit #(
    parameter int          QDEPTH   = 2,
    parameter logic [15:0] PC_RESET = lc3b_types::PC_RESET
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] mem_address,
    output logic        mem_read,
    input  logic [15:0] mem_rdata,
    input  logic        mem_resp,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        ir_ready,
    output logic        ir_valid,
    output logic [15:0] ir_word,
    output logic [15:0] ir_pc,
    output logic        ir_load
);

    import lc3b_types::*;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    localparam logic [2:0] QDEPTH_W = 3'(QDEPTH);

    logic [1:0]      state_q, state_d;
    lc3b_word        fetch_pc_q, fetch_pc_d;
    lc3b_word        req_addr_q, req_addr_d;
    lc3b_word        redirect_tgt;
    logic [1:0]      q_count;
    lc3b_fetch_entry q_head;
    lc3b_fetch_entry push_entry;
    logic            push;
    logic            pop;
    logic [2:0]      count_after;

    assign redirect_tgt = redirect_pc & 16'hFFFE;

    assign ir_valid = (q_count != 2'd0);
    assign ir_word  = q_head.word;
    assign ir_pc    = q_head.pc;
    assign ir_load  = ir_valid & ir_ready & ~redirect;
    assign pop      = ir_load;

    assign push_entry  = '{word: mem_rdata, pc: pc_inc(req_addr_q)};
    assign mem_address = req_addr_q;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_addr_d  = req_addr_q;
        mem_read    = 1'b0;
        push        = 1'b0;
        count_after = {1'b0, q_count};
        case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_tgt;
                end else if ({1'b0, q_count} < QDEPTH_W) begin
                    req_addr_d = fetch_pc_q;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                mem_read = 1'b1;
                if (redirect) begin
                    fetch_pc_d = redirect_tgt;
                    if (mem_resp) begin
                        // Response is stale; reissue straight at the target.
                        req_addr_d = redirect_tgt;
                    end else begin
                        // Request stays on the bus until memory answers it.
                        state_d = S_DROP;
                    end
                end else if (mem_resp) begin
                    push        = 1'b1;
                    fetch_pc_d  = pc_inc(fetch_pc_q);
                    count_after = {1'b0, q_count} + 3'd1 - {2'b0, pop};
                    if (count_after < QDEPTH_W) begin
                        req_addr_d = pc_inc(fetch_pc_q);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                mem_read = 1'b1;
                if (redirect) begin
                    fetch_pc_d = redirect_tgt;
                end
                if (mem_resp) begin
                    req_addr_d = redirect ? redirect_tgt : fetch_pc_q;
                    state_d    = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= PC_RESET;
            req_addr_q <= PC_RESET;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    fetch_queue u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .count      (q_count),
        .head       (q_head)
    );

endmodule
